// File: rtl/prog_seq_detect_if.sv
// Bus bundle for prog_seq_detect: serial bit stream, configuration strobe and match outputs.
// din is taken on a rising clk edge when din_valid=1; there is no ready, every valid bit is accepted.
interface prog_seq_detect_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LW      = $clog2(MAX_LEN + 1)
);
    logic               en;
    logic               din_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               z;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output en, din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  z, match_count
    );

    modport slave (
        input  en, din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output z, match_count
    );
endinterface

// File: rtl/prog_seq_detect.sv
// Programmable Moore serial-pattern detector with run-time pattern, length and overlap mode.
// Optional match counter enabled by defining SEQ_DET_COUNT_EN; otherwise match_count is 0.
module prog_seq_detect #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 DEF_LEN     = 4,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1100,
    parameter bit                 DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 16,
    localparam int                LW          = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    prog_seq_detect_if.slave     bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_HUNT  = 2'd2,
        S_MATCH = 2'd3
    } state_t;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_fill;
    logic               r_ovl;
    logic               r_z;

    logic               w_clr;
    logic [MAX_LEN-1:0] w_hist_base;
    logic [LW-1:0]      w_fill_base;
    logic [MAX_LEN-1:0] w_next_hist;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic [LW-1:0]      w_fill_inc;
    logic [LW-1:0]      w_cfg_len;

    // Non-overlap mode forgets the matched bits before the next bit is considered.
    assign w_clr       = (r_state == S_MATCH) && !r_ovl;
    assign w_hist_base = w_clr ? '0 : r_hist;
    assign w_fill_base = w_clr ? '0 : r_fill;
    assign w_next_hist = {w_hist_base[MAX_LEN-2:0], bus.din};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match    = (({1'b0, w_fill_base} + (LW+1)'(1)) >= {1'b0, r_len}) &&
                        (((w_next_hist ^ r_pat) & w_mask) == '0);
    assign w_fill_inc = (w_fill_base >= r_len) ? r_len : w_fill_base + LW'(1);

    always_comb begin
        w_cfg_len = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            w_cfg_len = LW'(1);
        end else if (int'(bus.cfg_len) > MAX_LEN) begin
            w_cfg_len = LW'(MAX_LEN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pat   <= DEF_PATTERN;
            r_len   <= LW'(DEF_LEN);
            r_ovl   <= DEF_OVERLAP;
            r_hist  <= '0;
            r_fill  <= '0;
            r_z     <= 1'b0;
        end else if (bus.cfg_load) begin
            r_pat   <= bus.cfg_pattern;
            r_len   <= w_cfg_len;
            r_ovl   <= bus.cfg_overlap;
            r_hist  <= '0;
            r_fill  <= '0;
            r_z     <= 1'b0;
            r_state <= bus.en ? S_FILL : S_IDLE;
        end else if (!bus.en) begin
            r_state <= S_IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_z     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_state <= S_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_z     <= 1'b0;
        end else if (bus.din_valid) begin
            r_hist <= w_next_hist;
            r_fill <= w_fill_inc;
            if (w_match) begin
                r_state <= S_MATCH;
                r_z     <= 1'b1;
            end else begin
                r_state <= (w_fill_inc == r_len) ? S_HUNT : S_FILL;
                r_z     <= 1'b0;
            end
        end else begin
            r_hist  <= w_hist_base;
            r_fill  <= w_fill_base;
            r_z     <= 1'b0;
            r_state <= (w_fill_base == r_len) ? S_HUNT : S_FILL;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_count;
    logic             w_cnt_inc;

    assign w_cnt_inc = bus.en && (r_state != S_IDLE) && bus.din_valid && w_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (bus.cfg_load) begin
            r_count <= '0;
        end else if (w_cnt_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.match_count = r_count;
`else
    assign bus.match_count = '0;
`endif

    assign bus.z       = r_z;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prog_seq_detect.sv
// Self-checking bench for prog_seq_detect: directed scenarios plus random traffic against
// a queue-based model of the matching rules.
module tb_prog_seq_detect;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_seq_detect_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();
    logic [1:0] dbg_state;

    prog_seq_detect #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: accepted bits since last clear, newest at the back
    bit               m_q[$];
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_act;
    bit               m_z;
    int               m_cnt;
    logic [CNT_W:0]   exp_q[$];

    task automatic model_reset();
        m_q.delete();
        m_pat = 8'b0000_1100;
        m_len = 4;
        m_ovl = 1'b1;
        m_act = 1'b0;
        m_z   = 1'b0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic en, input logic v, input logic d, input logic ld,
                              input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic o);
        bit hit;
        if (ld) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((int'(l) > MAX_LEN) ? MAX_LEN : int'(l));
            m_ovl = o;
            m_q.delete();
            m_z   = 1'b0;
            m_cnt = 0;
            m_act = en;
        end else if (!en) begin
            m_q.delete();
            m_z   = 1'b0;
            m_act = 1'b0;
        end else if (!m_act) begin
            m_act = 1'b1;
            m_q.delete();
            m_z   = 1'b0;
        end else begin
            if (m_z && !m_ovl) m_q.delete();
            if (v) begin
                m_q.push_back(d);
                if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                hit = (m_q.size() >= m_len);
                for (int i = 0; i < m_len; i++) begin
                    if (hit && (m_q[m_q.size()-1-i] != m_pat[i])) hit = 1'b0;
                end
                m_z = hit;
                if (hit && m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_z = 1'b0;
            end
        end
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef SEQ_DET_COUNT_EN
        return CNT_W'(m_cnt);
`else
        return '0;
`endif
    endfunction

    // driver tasks: drive after negedge, model at posedge, compare at next negedge
    task automatic step(input logic en, input logic v, input logic d, input logic ld,
                        input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic o);
        logic [CNT_W:0] e;
        bus.en = en; bus.din_valid = v; bus.din = d; bus.cfg_load = ld;
        bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = o;
        @(posedge clk);
        model_step(en, v, d, ld, p, l, o);
        exp_q.push_back({m_z, exp_cnt()});
        @(negedge clk);
        e = exp_q.pop_front();
        check_val("z", 32'(bus.z), 32'(e[CNT_W]));
        check_val("match_count", 32'(bus.match_count), 32'(e[CNT_W-1:0]));
    endtask

    task automatic send_bit(input logic d);
        step(1'b1, 1'b1, d, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic gap();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic o,
                        input logic v, input logic d);
        step(1'b1, v, d, 1'b1, p, l, o);
    endtask

    initial begin
        reset = 1'b1;
        bus.en = 1'b0; bus.din_valid = 1'b0; bus.din = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_z", 32'(bus.z), 32'd0);
        check_val("rst_cnt", 32'(bus.match_count), 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;

        // defaults: 1100, overlap
        gap();
        send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        check_val("t1_z", 32'(bus.z), 32'd1);
        gap();
        check_val("t1_z_low", 32'(bus.z), 32'd0);

        // 101 overlap then non-overlap
        load(8'b101, 3, 1'b1, 1'b0, 1'b0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
        gap();
        load(8'b101, 3, 1'b0, 1'b0, 1'b0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
        gap();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0); send_bit(1);
        check_val("t2_z6", 32'(bus.z), 32'd1);

        // gaps inside the pattern
        load(8'b1100, 4, 1'b1, 1'b0, 1'b0);
        send_bit(1); gap(); send_bit(1); send_bit(0); gap(); gap(); send_bit(0);
        check_val("t3_z", 32'(bus.z), 32'd1);
        gap();

        // load drops the same-cycle bit and flushes history
        send_bit(1); send_bit(1); send_bit(0);
        load(8'b1100, 4, 1'b1, 1'b1, 1'b0);
        send_bit(0);
        check_val("t4_noz", 32'(bus.z), 32'd0);
        send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        check_val("t4_z", 32'(bus.z), 32'd1);

        // asynchronous reset while z is high
        load(8'b1, 1, 1'b1, 1'b0, 1'b0);
        send_bit(1);
        #2 reset = 1'b1;
        #1;
        check_val("t5_async_z", 32'(bus.z), 32'd0);
        check_val("t5_async_cnt", 32'(bus.match_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        gap();
        send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        check_val("t5_restart_z", 32'(bus.z), 32'd1);

        // counter saturation, length clamps and en drop
        load(8'b1, 0, 1'b1, 1'b0, 1'b0);
        repeat (5) send_bit(1);
        load(8'hA5, 15, 1'b0, 1'b0, 1'b0);
        send_bit(1); send_bit(0); send_bit(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        gap();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            logic rl, ren, rv, rd, ro;
            logic [MAX_LEN-1:0] rp;
            logic [LW-1:0] rlen;
            rl   = ($urandom_range(0, 39) == 0);
            ren  = ($urandom_range(0, 29) != 0);
            rv   = ($urandom_range(0, 9) < 7);
            rd   = 1'($urandom_range(0, 1));
            ro   = 1'($urandom_range(0, 1));
            rp   = MAX_LEN'($urandom);
            rlen = ($urandom_range(0, 4) == 0) ? LW'($urandom_range(0, 15))
                                               : LW'($urandom_range(1, 3));
            step(ren, rv, rd, rl, rp, rlen, ro);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
